// File: rtl/request_framer.sv
// request_framer: turns two-byte UART frames (command, device address) into a
// one-cycle dispatch strobe with a latched command and a one-hot device select.
// Malformed frames, byte gaps, busy-time bytes and missing responses are
// reported through a one-cycle frame_error strobe and a sticky error_code.
//
// Handshake: has_request and finished are single-cycle strobes with no back-
// pressure; a byte is consumed (or reported dropped) in the cycle it is
// strobed. device_selected and frame_error are single-cycle registered strobes.
// request, device_selector and error_code are registered and hold between
// updates.
module request_framer #(
  parameter int NUM_DEVICES  = 32,
  parameter int NUM_COMMANDS = 8,
  parameter int BYTE_TIMEOUT = 2500000,
  parameter int RESP_TIMEOUT = 5000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        has_request,
  input  logic [7:0]  received_data,
  input  logic        finished,
  output logic        device_selected,
  output logic [7:0]  request,
  output logic [31:0] device_selector,
  output logic        frame_error,
  output logic [2:0]  error_code,
  output logic [1:0]  state_dbg
);

  // Timer is sized for the longer of the two timeouts and saturates there.
  localparam int TMAX = (BYTE_TIMEOUT > RESP_TIMEOUT) ? BYTE_TIMEOUT : RESP_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_SAT = TW'(TMAX);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_CMD  = 3'd1;
  localparam logic [2:0] ERR_BAD_ADDR = 3'd2;
  localparam logic [2:0] ERR_BYTE_TO  = 3'd3;
  localparam logic [2:0] ERR_BUSY     = 3'd4;
  localparam logic [2:0] ERR_RESP_TO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ADDR = 2'd1,
    S_DISPATCH  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [4:0]    addr_q, addr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] timer_inc;
  logic          dev_sel_q, dev_sel_d;
  logic [7:0]    req_q, req_d;
  logic [31:0]   sel_vec_q, sel_vec_d;
  logic          fe_q, fe_d;
  logic [2:0]    code_q, code_d;
  logic          cmd_ok;
  logic          addr_ok;

  // Validity of the held command and the incoming address byte.
  assign cmd_ok    = ({1'b0, cmd_q} < 9'(NUM_COMMANDS));
  assign addr_ok   = ({1'b0, received_data} < 9'(NUM_DEVICES));
  assign timer_inc = (timer_q == TIMER_SAT) ? timer_q : timer_q + 1'b1;

  // Next-state and next-output logic; every path starts from hold/idle defaults.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    timer_d   = timer_inc;
    req_d     = req_q;
    sel_vec_d = sel_vec_q;
    dev_sel_d = 1'b0;
    fe_d      = 1'b0;
    code_d    = code_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (has_request) begin
          cmd_d   = received_data;
          state_d = S_WAIT_ADDR;
        end
      end
      S_WAIT_ADDR: begin
        // A byte landing on the last timer cycle wins over the timeout.
        if (has_request) begin
          if (!cmd_ok) begin
            fe_d    = 1'b1;
            code_d  = ERR_BAD_CMD;
            state_d = S_IDLE;
          end else if (!addr_ok) begin
            fe_d    = 1'b1;
            code_d  = ERR_BAD_ADDR;
            state_d = S_IDLE;
          end else begin
            addr_d  = received_data[4:0];
            state_d = S_DISPATCH;
          end
        end else if (timer_q == BYTE_LAST) begin
          fe_d    = 1'b1;
          code_d  = ERR_BYTE_TO;
          state_d = S_IDLE;
        end
      end
      S_DISPATCH: begin
        // Bytes and finished strobes in this single cycle are ignored.
        dev_sel_d = 1'b1;
        req_d     = cmd_q;
        sel_vec_d = 32'd1 << addr_q;
        code_d    = ERR_NONE;
        timer_d   = '0;
        state_d   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // finished has priority; a timeout beats a busy-time byte.
        if (finished) begin
          if (has_request) begin
            cmd_d   = received_data;
            timer_d = '0;
            state_d = S_WAIT_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timer_q == RESP_LAST) begin
          fe_d    = 1'b1;
          code_d  = ERR_RESP_TO;
          state_d = S_IDLE;
        end else if (has_request) begin
          fe_d   = 1'b1;
          code_d = ERR_BUSY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame datapath, timer and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q     <= '0;
      addr_q    <= '0;
      timer_q   <= '0;
      dev_sel_q <= 1'b0;
      req_q     <= '0;
      sel_vec_q <= '0;
      fe_q      <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      dev_sel_q <= dev_sel_d;
      req_q     <= req_d;
      sel_vec_q <= sel_vec_d;
      fe_q      <= fe_d;
      code_q    <= code_d;
    end
  end

  assign device_selected = dev_sel_q;
  assign request         = req_q;
  assign device_selector = sel_vec_q;
  assign frame_error     = fe_q;
  assign error_code      = code_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_request_framer.sv
// Bench for request_framer: directed frames for each error/dispatch case plus
// randomized traffic, compared every cycle against a timestamp-based model.
module tb_request_framer;

  localparam int ND = 32;
  localparam int NC = 8;
  localparam int BT = 20;
  localparam int RT = 50;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        has_request;
  logic [7:0]  received_data;
  logic        finished;
  logic        device_selected;
  logic [7:0]  request;
  logic [31:0] device_selector;
  logic        frame_error;
  logic [2:0]  error_code;
  logic [1:0]  state_dbg;

  request_framer #(
    .NUM_DEVICES (ND),
    .NUM_COMMANDS(NC),
    .BYTE_TIMEOUT(BT),
    .RESP_TIMEOUT(RT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .has_request    (has_request),
    .received_data  (received_data),
    .finished       (finished),
    .device_selected(device_selected),
    .request        (request),
    .device_selector(device_selector),
    .frame_error    (frame_error),
    .error_code     (error_code),
    .state_dbg      (state_dbg)
  );

  // Clock.
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: frame progress tracked as cycle timestamps.
  bit          m_have_cmd;
  logic [7:0]  m_cmd;
  int          m_cmd_cyc;
  bit          m_disp_pend;
  logic [7:0]  m_disp_cmd;
  int          m_disp_addr;
  bit          m_busy;
  int          m_busy_start;
  logic        exp_sel;
  logic        exp_fe;
  logic [2:0]  exp_code;
  logic [7:0]  exp_req;
  logic [31:0] exp_dsel;
  logic [39:0] exp_q[$];

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_have_cmd  = 1'b0;
    m_cmd       = '0;
    m_cmd_cyc   = 0;
    m_disp_pend = 1'b0;
    m_disp_cmd  = '0;
    m_disp_addr = 0;
    m_busy      = 1'b0;
    m_busy_start = 0;
    exp_sel  = 1'b0;
    exp_fe   = 1'b0;
    exp_code = '0;
    exp_req  = '0;
    exp_dsel = '0;
    exp_q.delete();
  endtask

  task automatic model_err(input logic [2:0] c);
    exp_fe   = 1'b1;
    exp_code = c;
  endtask

  // Advance the model by one cycle with the inputs seen in cycle cyc;
  // leaves the expected outputs for cycle cyc+1.
  task automatic model_step(input bit hr, input logic [7:0] d, input bit fin);
    exp_sel = 1'b0;
    exp_fe  = 1'b0;
    if (m_disp_pend) begin
      m_disp_pend  = 1'b0;
      exp_sel      = 1'b1;
      exp_req      = m_disp_cmd;
      exp_dsel     = 32'd1 << m_disp_addr;
      exp_code     = 3'd0;
      exp_q.push_back({m_disp_cmd, 32'd1 << m_disp_addr});
      m_busy       = 1'b1;
      m_busy_start = cyc + 1;
    end else if (m_busy) begin
      if (fin) begin
        m_busy = 1'b0;
        if (hr) begin
          m_have_cmd = 1'b1;
          m_cmd      = d;
          m_cmd_cyc  = cyc;
        end
      end else if (cyc - m_busy_start == RT - 1) begin
        model_err(3'd5);
        m_busy = 1'b0;
      end else if (hr) begin
        model_err(3'd4);
      end
    end else if (m_have_cmd) begin
      if (hr) begin
        m_have_cmd = 1'b0;
        if (int'(m_cmd) >= NC) model_err(3'd1);
        else if (int'(d) >= ND) model_err(3'd2);
        else begin
          m_disp_pend = 1'b1;
          m_disp_cmd  = m_cmd;
          m_disp_addr = int'(d);
        end
      end else if (cyc - m_cmd_cyc == BT) begin
        model_err(3'd3);
        m_have_cmd = 1'b0;
      end
    end else if (hr) begin
      m_have_cmd = 1'b1;
      m_cmd      = d;
      m_cmd_cyc  = cyc;
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input bit hr, input logic [7:0] d, input bit fin);
    logic [39:0] rec;
    has_request   = hr;
    received_data = hr ? d : 8'($urandom);
    finished      = fin;
    @(negedge clock);
    check("device_selected", 40'(device_selected), 40'(exp_sel));
    check("frame_error", 40'(frame_error), 40'(exp_fe));
    check("error_code", 40'(error_code), 40'(exp_code));
    check("request", 40'(request), 40'(exp_req));
    check("device_selector", 40'(device_selector), 40'(exp_dsel));
    if (device_selected) begin
      check("dispatch_expected", 40'(exp_q.size() > 0), 40'd1);
      if (exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        check("dispatch_record", {request, device_selector}, rec);
      end
    end
    model_step(hr, d, fin);
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Reset held for n falling edges; outputs must read as all zero meanwhile.
  task automatic do_reset(input int n);
    reset_n     = 1'b0;
    has_request = 1'b0;
    finished    = 1'b0;
    received_data = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("rst_device_selected", 40'(device_selected), 40'd0);
      check("rst_frame_error", 40'(frame_error), 40'd0);
      check("rst_error_code", 40'(error_code), 40'd0);
      check("rst_request", 40'(request), 40'd0);
      check("rst_device_selector", 40'(device_selector), 40'd0);
      check("rst_idle", 40'(state_dbg), 40'd0);
      cyc++;
      @(posedge clock);
      #1;
    end
    model_clear();
    reset_n = 1'b1;
  endtask

  initial begin
    int rate;
    bit hr;
    bit fin;
    logic [7:0] d;
    model_clear();
    do_reset(3);

    // Good frame: command 3 to device 5.
    step(1, 8'h03, 0); step(1, 8'h05, 0); idle(3); step(0, 8'h00, 1); idle(2);
    // Bad command, then bad address.
    step(1, 8'h09, 0); step(1, 8'h40, 0); idle(2);
    step(1, 8'h02, 0); step(1, 8'h20, 0); idle(2);
    // Byte timeout, then a good frame to device 0.
    step(1, 8'h01, 0); idle(22);
    step(1, 8'h01, 0); step(1, 8'h00, 0); idle(3); step(0, 8'h00, 1);
    // Address byte on the very last allowed cycle is accepted.
    step(1, 8'h02, 0); idle(BT - 1); step(1, 8'h07, 0); idle(3); step(0, 8'h00, 1);
    // Busy drop, then finished plus a new command byte together.
    step(1, 8'h03, 0); step(1, 8'h04, 0); idle(3); step(1, 8'h04, 0); idle(2);
    step(1, 8'h02, 1); step(1, 8'h1F, 0); idle(3); step(0, 8'h00, 1);
    // finished while idle is ignored.
    step(0, 8'h00, 1); idle(1);
    // Response timeout.
    step(1, 8'h00, 0); step(1, 8'h01, 0); idle(55);
    // Reset between the two bytes, then a normal frame.
    step(1, 8'h03, 0); do_reset(2);
    step(1, 8'h03, 0); step(1, 8'h05, 0); idle(3); step(0, 8'h00, 1); idle(2);

    // Randomized traffic with varying byte density.
    rate = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 2;
          1: rate = 10;
          default: rate = 35;
        endcase
      end
      hr  = ($urandom_range(0, 99) < rate);
      d   = $urandom_range(0, 1) ? 8'($urandom_range(0, 11)) : 8'($urandom_range(0, 40));
      if ($urandom_range(0, 15) == 0) d = 8'($urandom_range(0, 255));
      fin = (m_busy && $urandom_range(0, 14) == 0) || ($urandom_range(0, 99) == 0);
      step(hr, d, fin);
    end
    idle(4);
    check("dispatch_queue_empty", 40'(exp_q.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/request_framer.md
REQUEST_FRAMER -- requirements
Module: request_framer

Interface
REQ-001 Parameter: NUM_DEVICES, 32, count of addressable sensors; legal device addresses are 0..NUM_DEVICES-1 (range 1..32).
REQ-002 Parameter: NUM_COMMANDS, 8, count of legal command codes; legal command codes are 0..NUM_COMMANDS-1.
REQ-003 Parameter: BYTE_TIMEOUT, 2500000, maximum number of clock cycles between command byte and address byte.
REQ-004 Parameter: RESP_TIMEOUT, 5000000, maximum number of clock cycles between dispatch and finished.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port: clock  in  1  the single system clock; all logic rising-edge.
REQ-007 Port: reset_n  in  1  asynchronous active-low reset.
REQ-008 Port: has_request  in  1  one-cycle strobe, UART receiver byte valid.
REQ-009 Port: received_data  in  8  received byte, valid while has_request is high.
REQ-010 Port: finished  in  1  one-cycle strobe from the sensor decoder, transaction complete.
REQ-011 Port: device_selected  out  1  one-cycle dispatch strobe.
REQ-012 Port: request  out  8  latched command byte.
REQ-013 Port: device_selector  out  32  one-hot device select; bits at index NUM_DEVICES and above are always 0.
REQ-014 Port: frame_error  out  1  one-cycle error strobe.
REQ-015 Port: error_code  out  3  last error: 0 none, 1 BAD_CMD, 2 BAD_ADDR, 3 BYTE_TIMEOUT, 4 BUSY_DROP, 5 RESP_TIMEOUT.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, WAIT_ADDR, DISPATCH, WAIT_DONE.
REQ-017 Frame format SHALL be two bytes: byte 0 is the command, byte 1 is the device address.
REQ-018 IDLE with has_request: the block SHALL latch received_data into the command register, clear the timer, and go to WAIT_ADDR.
REQ-019 WAIT_ADDR with has_request, command >= NUM_COMMANDS: the block SHALL pulse frame_error with code 1 and return to IDLE.
REQ-020 WAIT_ADDR with has_request, address >= NUM_DEVICES: the block SHALL pulse frame_error with code 2 and return to IDLE.
REQ-021 Command validity SHALL be checked before address validity, so code 1 wins when both are bad.
REQ-022 WAIT_ADDR with has_request, both command and address valid: the block SHALL go to DISPATCH.
REQ-023 WAIT_ADDR timer reaching BYTE_TIMEOUT-1 with no byte: the block SHALL pulse code 3 and return to IDLE.
REQ-024 A byte arriving in the same cycle the byte timeout expires SHALL be accepted, with no timeout error.
REQ-025 DISPATCH: device_selected SHALL be high for exactly one cycle, with request and device_selector already stable in that cycle.
REQ-026 DISPATCH: the block SHALL then go to WAIT_DONE and clear the timer.
REQ-027 A valid frame SHALL produce device_selected 2 cycles after the address strobe (address strobe at cycle N, device_selected at cycle N+2).
REQ-028 request and device_selector SHALL hold their values from DISPATCH until the next DISPATCH.
REQ-029 device_selector SHALL equal 1 shifted left by the address.
REQ-030 WAIT_DONE with finished: the block SHALL return to IDLE.
REQ-031 WAIT_DONE with has_request and no finished: the byte SHALL be dropped, frame_error pulsed with code 4, and the state held.
REQ-032 WAIT_DONE with finished and has_request in the same cycle: the byte SHALL be taken as a new command byte and the block SHALL go to WAIT_ADDR, with no error.
REQ-033 WAIT_DONE timer reaching RESP_TIMEOUT-1 without finished: the block SHALL pulse code 5 and return to IDLE.
REQ-034 finished received outside WAIT_DONE SHALL be ignored.
REQ-035 error_code SHALL hold its value until the next error; a successful DISPATCH SHALL clear it to 0.
REQ-036 Timer width SHALL be sized from the larger of BYTE_TIMEOUT and RESP_TIMEOUT, and the timer SHALL never wrap.

Reset
REQ-037 While reset_n is low, the block SHALL be in IDLE, with device_selected, frame_error and request at 0, device_selector at 0 (no device selected), error_code at 0, and the timer at 0.
REQ-038 Reset asserted mid-frame or in WAIT_DONE SHALL discard the partial frame with no strobe generated.
REQ-039 After reset_n rises, the first has_request SHALL be treated as a command byte.

Verification (NUM_DEVICES=32, NUM_COMMANDS=8, BYTE_TIMEOUT=20, RESP_TIMEOUT=50)
REQ-040 Bytes 0x03 then 0x05 -> 2 cycles after the second strobe, device_selected pulses for 1 cycle with request=0x03, device_selector=0x00000020, error_code=0.
REQ-041 Bytes 0x09 then 0x40 -> frame_error pulses with error_code=1 and no device_selected occurs; bytes 0x02 then 0x20 -> error_code=2.
REQ-042 Byte 0x01 followed by 20 idle cycles -> error_code=3 and return to IDLE; next bytes 0x01, 0x00 -> dispatch with device_selector=0x00000001.
REQ-043 Valid frame, then byte 0x04 during WAIT_DONE -> error_code=4 with no state change; finished and byte 0x02 in the same cycle -> new frame starts; following byte 0x1F -> device_selector=0x80000000.
REQ-044 Valid frame, then no finished for 50 cycles -> error_code=5 and return to IDLE.
REQ-045 reset_n pulsed low between the two bytes of a frame -> all outputs at 0 and no strobe; a subsequent full frame dispatches normally.
